sad_ctrl: RTL and testbench

SAD_CTRL -- requirements
Module: sad_ctrl

---
 rtl/sad_ctrl.sv | 114 +++++++++++
 tb/tb_sad_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_ctrl.sv
// sad_ctrl: control FSM for a sum-of-absolute-differences datapath.
// Each run clears the index and accumulator, then loops CHECK -> [WAIT] -> ACC
// while the datapath reports index < 256. It finishes with STORE and DONE. A
// watchdog counts ACC iterations and ends the run in ERR if the limit is reached.
//
// Parameters
//   MEM_LAT   : sample memory read latency (0 or 1); 1 inserts a WAIT per iteration
//   MAX_ITER  : watchdog limit on ACC iterations per run
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   go            : start request (sampled in IDLE only)
//   abort         : cancel run (honoured in INIT/CHECK/WAIT/ACC)
//   sad_clr_req   : clear request for the result register (IDLE only)
//   i_lt_256      : datapath status, index below 256
//   i_inc, i_clr  : index increment / clear
//   sum_ld, sum_clr     : accumulator load / clear
//   sadreg_ld, sadreg_clr : result register load / clear (sadreg_clr is combinational)
//   busy          : high outside IDLE
//   done, err     : one-cycle completion / watchdog pulses
module sad_ctrl #(
  parameter int unsigned MEM_LAT  = 0,
  parameter int unsigned MAX_ITER = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic abort,
  input  logic sad_clr_req,
  input  logic i_lt_256,
  output logic i_inc,
  output logic i_clr,
  output logic sum_ld,
  output logic sum_clr,
  output logic sadreg_ld,
  output logic sadreg_clr,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned CW = $clog2(MAX_ITER) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_CHECK, S_WAIT, S_ACC, S_STORE, S_DONE, S_ERR
  } state_t;

  state_t          state;
  logic [CW-1:0]   iter;
  logic [7:0]      outs_q;

  // Moore output decode, bit order {busy,i_clr,sum_clr,sum_ld,i_inc,sadreg_ld,done,err}
  function automatic logic [7:0] outs_of(input state_t s);
    logic [7:0] o;
    o = 8'b0000_0000;
    case (s)
      S_INIT:          o = 8'b1110_0000;
      S_CHECK, S_WAIT: o = 8'b1000_0000;
      S_ACC:           o = 8'b1001_1000;
      S_STORE:         o = 8'b1000_0100;
      S_DONE:          o = 8'b1000_0010;
      S_ERR:           o = 8'b1000_0001;
      default:         o = 8'b0000_0000;
    endcase
    return o;
  endfunction

  // Next-state rules; abort outranks every CHECK transition
  function automatic state_t next_of(input state_t s, input logic req,
                                     input logic cancel, input logic more,
                                     input logic [CW-1:0] cnt);
    state_t n;
    n = s;
    case (s)
      S_IDLE:  if (req) n = S_INIT;
      S_INIT:  n = cancel ? S_IDLE : S_CHECK;
      S_CHECK: begin
        if (cancel)                     n = S_IDLE;
        else if (!more)                 n = S_STORE;
        else if (cnt < CW'(MAX_ITER))   n = (MEM_LAT != 0) ? S_WAIT : S_ACC;
        else                            n = S_ERR;
      end
      S_WAIT:  n = cancel ? S_IDLE : S_ACC;
      S_ACC:   n = cancel ? S_IDLE : S_CHECK;
      S_STORE: n = S_DONE;
      S_DONE:  n = S_IDLE;
      S_ERR:   n = S_IDLE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  // State, registered outputs (decoded from the state being entered) and watchdog counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      outs_q <= 8'b0000_0000;
      iter   <= '0;
    end else begin
      state  <= next_of(state, go, abort, i_lt_256, iter);
      outs_q <= outs_of(next_of(state, go, abort, i_lt_256, iter));
      if (state == S_INIT) begin
        iter <= '0;
      end else if (state == S_ACC && iter != CW'(MAX_ITER)) begin
        iter <= iter + CW'(1);
      end
    end
  end

  assign {busy, i_clr, sum_clr, sum_ld, i_inc, sadreg_ld, done, err} = outs_q;

  // Clear request passes straight through while idle; forced low during reset
  assign sadreg_clr = !rst && (state == S_IDLE) && sad_clr_req;

endmodule

// File: tb/tb_sad_ctrl.sv
// tb_sad_ctrl: self-checking bench for sad_ctrl.
// Three instances: u0 (MEM_LAT=0, MAX_ITER=256), u1 (MEM_LAT=1, MAX_ITER=256),
// u2 (MEM_LAT=0, MAX_ITER=4). Each has its own index model whose 256 limit is
// replaced by a per-run programmable limit so run lengths can be randomised.
module tb_sad_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] go = '0, abort = '0, sad_clr_req = '0;
  wire  [2:0] i_lt_256, i_inc, i_clr, sum_ld, sum_clr, sadreg_ld, sadreg_clr;
  wire  [2:0] busy, done, err;
  int         idx [3] = '{0, 0, 0};
  int         lim [3] = '{256, 256, 256};
  int         checks = 0;
  int         errors = 0;

  // Expected output vectors {busy,i_clr,sum_clr,sum_ld,i_inc,sadreg_ld,done,err}
  localparam logic [7:0] V_IDLE  = 8'b0000_0000;
  localparam logic [7:0] V_INIT  = 8'b1110_0000;
  localparam logic [7:0] V_CHK   = 8'b1000_0000;
  localparam logic [7:0] V_WAIT  = 8'b1000_0000;
  localparam logic [7:0] V_ACC   = 8'b1001_1000;
  localparam logic [7:0] V_STORE = 8'b1000_0100;
  localparam logic [7:0] V_DONE  = 8'b1000_0010;
  localparam logic [7:0] V_ERR   = 8'b1000_0001;

  always #5 clk = ~clk;

  sad_ctrl #(.MEM_LAT(0), .MAX_ITER(256)) u0 (
    .clk(clk), .rst(rst), .go(go[0]), .abort(abort[0]), .sad_clr_req(sad_clr_req[0]),
    .i_lt_256(i_lt_256[0]), .i_inc(i_inc[0]), .i_clr(i_clr[0]), .sum_ld(sum_ld[0]),
    .sum_clr(sum_clr[0]), .sadreg_ld(sadreg_ld[0]), .sadreg_clr(sadreg_clr[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]));

  sad_ctrl #(.MEM_LAT(1), .MAX_ITER(256)) u1 (
    .clk(clk), .rst(rst), .go(go[1]), .abort(abort[1]), .sad_clr_req(sad_clr_req[1]),
    .i_lt_256(i_lt_256[1]), .i_inc(i_inc[1]), .i_clr(i_clr[1]), .sum_ld(sum_ld[1]),
    .sum_clr(sum_clr[1]), .sadreg_ld(sadreg_ld[1]), .sadreg_clr(sadreg_clr[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]));

  sad_ctrl #(.MEM_LAT(0), .MAX_ITER(4)) u2 (
    .clk(clk), .rst(rst), .go(go[2]), .abort(abort[2]), .sad_clr_req(sad_clr_req[2]),
    .i_lt_256(i_lt_256[2]), .i_inc(i_inc[2]), .i_clr(i_clr[2]), .sum_ld(sum_ld[2]),
    .sum_clr(sum_clr[2]), .sadreg_ld(sadreg_ld[2]), .sadreg_clr(sadreg_clr[2]),
    .busy(busy[2]), .done(done[2]), .err(err[2]));

  // Datapath index model
  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (i_clr[n])      idx[n] <= 0;
      else if (i_inc[n]) idx[n] <= idx[n] + 1;
    end
  end

  assign i_lt_256[0] = (idx[0] < lim[0]);
  assign i_lt_256[1] = (idx[1] < lim[1]);
  assign i_lt_256[2] = (idx[2] < lim[2]);

  function automatic bit lat_of(input int n);
    return (n == 1);
  endfunction

  function automatic int maxit_of(input int n);
    return (n == 2) ? 4 : 256;
  endfunction

  function automatic logic [7:0] vec(input int n);
    return {busy[n], i_clr[n], sum_clr[n], sum_ld[n], i_inc[n], sadreg_ld[n], done[n], err[n]};
  endfunction

  // Build the expected per-cycle trace from the run rules, drive go/abort, compare every cycle.
  // abort_k: ACC iteration (0-based) of the first run in which abort is raised, -1 for none.
  // noise: raise abort during STORE/DONE/ERR, which must be ignored.
  task automatic run_check(input int n, input int lm, input int abort_k, input int nruns,
                           input bit clr, input bit noise, input string tag);
    logic [7:0] exp_q[$];
    bit         ab_q[$];
    int         init2;
    int         k;
    bit         fin;
    logic [7:0] obs;
    init2 = -1;
    for (int r = 0; r < nruns; r++) begin
      if (r == 1) init2 = exp_q.size();
      exp_q.push_back(V_INIT); ab_q.push_back(1'b0);
      k = 0;
      fin = 1'b0;
      while (!fin) begin
        exp_q.push_back(V_CHK); ab_q.push_back(1'b0);
        if (k >= lm) begin
          exp_q.push_back(V_STORE); ab_q.push_back(noise);
          exp_q.push_back(V_DONE);  ab_q.push_back(noise);
          fin = 1'b1;
        end else if (k >= maxit_of(n)) begin
          exp_q.push_back(V_ERR); ab_q.push_back(noise);
          fin = 1'b1;
        end else begin
          if (lat_of(n)) begin
            exp_q.push_back(V_WAIT); ab_q.push_back(1'b0);
          end
          exp_q.push_back(V_ACC);
          if (r == 0 && k == abort_k) begin
            ab_q.push_back(1'b1);
            fin = 1'b1;
          end else begin
            ab_q.push_back(1'b0);
          end
          k++;
        end
      end
      exp_q.push_back(V_IDLE); ab_q.push_back(1'b0);
    end
    exp_q.push_back(V_IDLE); ab_q.push_back(1'b0);

    lim[n] = lm;
    @(negedge clk);
    go[n] = 1'b1;
    sad_clr_req[n] = clr;
    #1;
    checks++;
    if (sadreg_clr[n] !== clr) begin
      errors++;
      $display("FAIL %s u%0d sadreg_clr on go cycle: got %b want %b", tag, n, sadreg_clr[n], clr);
    end
    for (int p = 0; p < exp_q.size(); p++) begin
      @(negedge clk);
      if (p == 0) begin
        sad_clr_req[n] = 1'b0;
        if (nruns == 1) go[n] = 1'b0;
      end
      if (p == init2) go[n] = 1'b0;
      obs = vec(n);
      checks++;
      if (obs !== exp_q[p]) begin
        errors++;
        $display("FAIL %s u%0d cycle %0d outputs: got %b want %b", tag, n, p + 1, obs, exp_q[p]);
      end
      abort[n] = ab_q[p];
    end
    abort[n] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    go = 3'b111;
    sad_clr_req = 3'b111;
    repeat (3) @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (vec(n) !== V_IDLE || sadreg_clr[n] !== 1'b0) begin
        errors++;
        $display("FAIL reset u%0d outputs: got %b/%b want %b/0", n, vec(n), sadreg_clr[n], V_IDLE);
      end
    end
    go = '0;
    rst = 1'b0;
    #1;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (sadreg_clr[n] !== 1'b1) begin
        errors++;
        $display("FAIL reset u%0d idle sadreg_clr: got %b want 1", n, sadreg_clr[n]);
      end
    end
    sad_clr_req = '0;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (vec(n) !== V_IDLE || sadreg_clr[n] !== 1'b0) begin
        errors++;
        $display("FAIL reset u%0d after release: got %b/%b want %b/0", n, vec(n), sadreg_clr[n], V_IDLE);
      end
    end
  endtask

  task automatic test_nominal_lat0();
    run_check(0, 256, -1, 1, 1'b0, 1'b0, "nominal_lat0");
  endtask

  task automatic test_nominal_lat1();
    run_check(1, 256, -1, 1, 1'b0, 1'b0, "nominal_lat1");
  endtask

  task automatic test_watchdog();
    run_check(2, 256, -1, 1, 1'b0, 1'b0, "watchdog");
    run_check(2, 4, -1, 1, 1'b0, 1'b1, "watchdog_edge4");
    run_check(2, 5, -1, 1, 1'b0, 1'b1, "watchdog_edge5");
  endtask

  task automatic test_abort();
    abort[0] = 1'b1;
    run_check(0, 256, 9, 1, 1'b0, 1'b0, "abort_acc10");
    run_check(0, 6, -1, 1, 1'b1, 1'b1, "after_abort");
    run_check(1, 8, 3, 1, 1'b0, 1'b0, "abort_lat1");
  endtask

  task automatic test_rst_mid_run();
    lim[0] = 256;
    @(negedge clk);
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (vec(0) !== V_CHK) begin
      errors++;
      $display("FAIL rst_mid_run pre-reset state: got %b want %b", vec(0), V_CHK);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (vec(0) !== V_IDLE || sadreg_clr[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_run async clear: got %b/%b want %b/0", vec(0), sadreg_clr[0], V_IDLE);
    end
    sad_clr_req[0] = 1'b1;
    #1;
    checks++;
    if (sadreg_clr[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_run sadreg_clr in reset: got %b want 0", sadreg_clr[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (sadreg_clr[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_run sadreg_clr idle: got %b want 1", sadreg_clr[0]);
    end
    sad_clr_req[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (vec(0) !== V_IDLE) begin
        errors++;
        $display("FAIL rst_mid_run stays idle: got %b want %b", vec(0), V_IDLE);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_check(0, 256, -1, 2, 1'b0, 1'b0, "back_to_back_lat0");
    run_check(1, 5, -1, 2, 1'b1, 1'b0, "back_to_back_lat1");
    run_check(2, 9, -1, 2, 1'b0, 1'b1, "back_to_back_err");
  endtask

  task automatic test_random();
    int n, lm, ak;
    for (int t = 0; t < 24; t++) begin
      n  = int'($urandom_range(0, 2));
      lm = int'($urandom_range(0, 12));
      ak = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : -1;
      run_check(n, lm, ak, int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), "random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_nominal_lat0();
    test_nominal_lat1();
    test_watchdog();
    test_abort();
    test_rst_mid_run();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
